// File: rtl/asip_seq_pkg.sv
// Shared definitions for the vector execute sequencer: FSM states, ExecuteOp codes
// and elaboration-time width helpers.
package asip_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // ExecuteOp codes understood by the execute-stage ALU lanes
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/seq_flag_accumulator.sv
// Accumulates N/Z across the chunks of one command, ignoring disabled lanes.
// o_*_nxt include the chunk currently presented so the final flags can load on its accept.
module seq_flag_accumulator #(
  parameter int NUM_LANES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [NUM_LANES-1:0] i_lane_en,
  input  logic [NUM_LANES-1:0] i_neg,
  input  logic [NUM_LANES-1:0] i_zero,
  output logic                 o_acc_n_nxt,
  output logic                 o_acc_z_nxt
);

  logic                 r_acc_n;
  logic                 r_acc_z;
  logic [NUM_LANES-1:0] w_neg_m;
  logic [NUM_LANES-1:0] w_zero_m;

  // disabled lanes must look "not negative" and "zero" so they never disturb the result
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign w_neg_m[l]  = i_neg[l] & i_lane_en[l];
    assign w_zero_m[l] = i_zero[l] | ~i_lane_en[l];
  end

  assign o_acc_n_nxt = r_acc_n | (|w_neg_m);
  assign o_acc_z_nxt = r_acc_z & (&w_zero_m);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_n <= 1'b0;
      r_acc_z <= 1'b1;
    end else if (i_clr) begin
      r_acc_n <= 1'b0;
      r_acc_z <= 1'b1;
    end else if (i_en) begin
      r_acc_n <= o_acc_n_nxt;
      r_acc_z <= o_acc_z_nxt;
    end
  end

endmodule

// File: rtl/vector_exec_sequencer.sv
// Steps one vector command through ceil(len/vectorSize) ALU chunks and updates N/Z flags.
// Optional abort input enabled by defining VECTOR_SEQ_ABORT_EN.
module vector_exec_sequencer
  import asip_seq_pkg::*;
#(
  parameter  int registerSize = 8,
  parameter  int vectorSize   = 4,
  parameter  int maxElems     = 32,
  localparam int LW           = $clog2(maxElems + 1),
  localparam int CW           = clog2_min1(ceil_div(maxElems, vectorSize))
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [LW-1:0]         cmd_len,
  input  logic                  cmd_setFlags,
  output logic [2:0]            ExecuteOp,
  output logic [CW-1:0]         chunk_idx,
  output logic [vectorSize-1:0] lane_en,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_last,
  input  logic [vectorSize-1:0] negativeFlags,
  input  logic [vectorSize-1:0] zeroFlags,
  output logic                  neg_flag,
  output logic                  zero_flag,
`ifdef VECTOR_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  done
);

  if (registerSize < 1 || vectorSize < 1 || maxElems < 1) begin : g_bad_cfg
    $error("vector_exec_sequencer: registerSize, vectorSize and maxElems must be positive");
  end

  seq_state_e            r_state;
  logic [2:0]            r_op;
  logic                  r_set;
  logic [CW-1:0]         r_chunk;
  logic [CW-1:0]         r_last_idx;
  logic [vectorSize-1:0] r_last_mask;

  logic [LW-1:0]         w_lm1;
  logic [LW-1:0]         w_rem;
  logic [CW-1:0]         w_last_idx;
  logic [vectorSize-1:0] w_last_mask;
  logic                  w_run;
  logic                  w_is_last;
  logic                  w_abort;
  logic                  w_accept;
  logic                  w_chunk_acc;
  logic                  w_acc_n_nxt;
  logic                  w_acc_z_nxt;

`ifdef VECTOR_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // final-chunk geometry is worked out once at accept; only meaningful when len > 0
  assign w_lm1      = cmd_len - LW'(1);
  assign w_rem      = w_lm1 % LW'(vectorSize);
  assign w_last_idx = CW'(w_lm1 / LW'(vectorSize));
  for (genvar l = 0; l < vectorSize; l++) begin : g_mask
    assign w_last_mask[l] = (LW'(l) <= w_rem);
  end

  assign w_run       = (r_state == RUN);
  assign w_is_last   = (r_chunk == r_last_idx);
  assign w_accept    = (r_state == IDLE) & cmd_valid;
  assign w_chunk_acc = w_run & res_ready & ~w_abort;

  assign cmd_ready = (r_state == IDLE);
  assign res_valid = w_run;
  assign done      = (r_state == DONE);
  assign chunk_idx = r_chunk;
  assign ExecuteOp = w_run ? r_op : OP_NOP;
  assign res_last  = w_run & w_is_last;
  assign lane_en   = w_run ? (w_is_last ? r_last_mask : '1) : '0;

  seq_flag_accumulator #(.NUM_LANES(vectorSize)) u_acc (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_accept),
    .i_en        (w_chunk_acc),
    .i_lane_en   (lane_en),
    .i_neg       (negativeFlags),
    .i_zero      (zeroFlags),
    .o_acc_n_nxt (w_acc_n_nxt),
    .o_acc_z_nxt (w_acc_z_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= OP_NOP;
      r_set       <= 1'b0;
      r_chunk     <= '0;
      r_last_idx  <= '0;
      r_last_mask <= '0;
      neg_flag    <= 1'b0;
      zero_flag   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_op        <= cmd_op;
          r_set       <= cmd_setFlags;
          r_chunk     <= '0;
          r_last_idx  <= w_last_idx;
          r_last_mask <= w_last_mask;
          r_state     <= (cmd_len != '0) ? RUN : DONE;
        end
        RUN: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (res_ready) begin
            if (w_is_last) begin
              r_state <= DONE;
              if (r_set) begin
                neg_flag  <= w_acc_n_nxt;
                zero_flag <= w_acc_z_nxt;
              end
            end else begin
              r_chunk <= r_chunk + CW'(1);
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Randomized and directed checks of vector_exec_sequencer against an element-level model.
// Abort scenario is exercised only when VECTOR_SEQ_ABORT_EN is defined.
module tb_vector_exec_sequencer;

  localparam int VS = 4;
  localparam int ME = 32;
  localparam int LW = $clog2(ME + 1);
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_setFlags = 1'b0;
  logic [2:0]    ExecuteOp;
  logic [CW-1:0] chunk_idx;
  logic [VS-1:0] lane_en;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          res_last;
  logic [VS-1:0] negativeFlags = '0;
  logic [VS-1:0] zeroFlags = '0;
  logic          neg_flag;
  logic          zero_flag;
  logic          done;
`ifdef VECTOR_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit mn = 0;  // model architectural flags
  bit mz = 0;

  vector_exec_sequencer #(.registerSize(8), .vectorSize(VS), .maxElems(ME)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_len       (cmd_len),
    .cmd_setFlags  (cmd_setFlags),
    .ExecuteOp     (ExecuteOp),
    .chunk_idx     (chunk_idx),
    .lane_en       (lane_en),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_last      (res_last),
    .negativeFlags (negativeFlags),
    .zeroFlags     (zeroFlags),
    .neg_flag      (neg_flag),
    .zero_flag     (zero_flag),
`ifdef VECTOR_SEQ_ABORT_EN
    .abort         (abort),
`endif
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // fmode: 0 random-ish flags, 1 all lanes zero/non-negative, 2 all lanes negative/non-zero
  task automatic drive_flags(input int fmode);
    case (fmode)
      1: begin negativeFlags = '0; zeroFlags = '1; end
      2: begin negativeFlags = '1; zeroFlags = '0; end
      default: begin
        negativeFlags = ($urandom_range(3) == 0) ? VS'($urandom) : '0;
        zeroFlags     = ($urandom_range(3) == 0) ? VS'($urandom) : '1;
      end
    endcase
  endtask

  task automatic run_cmd(input int len, input logic [2:0] op, input bit setf,
                         input int stall_n, input int stall_pct, input int fmode);
    int nch, c, guard, base, cnt;
    bit an, az, rdy;
    logic [VS-1:0] m;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LW'(len); cmd_setFlags = setf;
    #1 chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    nch = (len + VS - 1) / VS;
    an = 1'b0; az = 1'b1; c = 0; guard = 0;
    while (c < nch && guard < 300) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      rdy = (guard >= stall_n) && ($urandom_range(99) >= 32'(stall_pct));
      res_ready = rdy;
      drive_flags(fmode);
      guard++;
      base = c * VS;
      cnt  = (len - base >= VS) ? VS : len - base;
      m = '0;
      for (int l = 0; l < cnt; l++) m[l] = 1'b1;
      #1;
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("chunk_idx", 32'(chunk_idx), 32'(c));
      chk("lane_en", 32'(lane_en), 32'(m));
      chk("res_last", 32'(res_last), 32'(c == nch - 1));
      chk("ExecuteOp", 32'(ExecuteOp), 32'(op));
      chk("no_done_run", 32'(done), 32'd0);
      chk("cmd_ready_run", 32'(cmd_ready), 32'd0);
      if (rdy) begin
        for (int e = base; e < base + cnt; e++) begin
          if (negativeFlags[e - base]) an = 1'b1;
          if (!zeroFlags[e - base])    az = 1'b0;
        end
        c++;
      end
    end
    if (guard >= 300) chk("run_timeout", 32'd1, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0; res_ready = 1'b0;
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("res_valid_done", 32'(res_valid), 32'd0);
    chk("cmd_ready_done", 32'(cmd_ready), 32'd0);
    chk("ExecuteOp_done", 32'(ExecuteOp), 32'd0);
    chk("lane_en_done", 32'(lane_en), 32'd0);
    if (setf && len > 0) begin mn = an; mz = az; end
    chk("neg_flag", 32'(neg_flag), 32'(mn));
    chk("zero_flag", 32'(zero_flag), 32'(mz));
    @(negedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_chunk_idx", 32'(chunk_idx), 32'd0);
    chk("rst_neg", 32'(neg_flag), 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd0);
    chk("rst_lane_en", 32'(lane_en), 32'd0);

    // directed scenarios
    run_cmd(8, 3'd3, 1'b1, 0, 0, 1);   // two full chunks, Z=1 N=0
    run_cmd(6, 3'd1, 1'b1, 0, 0, 1);   // partial final chunk
    // negative only on a masked lane of the partial chunk
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_len = LW'(6); cmd_setFlags = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; res_ready = 1'b1; negativeFlags = '0; zeroFlags = '1;
    @(negedge clk);
    negativeFlags = 4'b1000; zeroFlags = 4'b0011;
    #1 chk("masked_lane_en", 32'(lane_en), 32'h3);
    @(negedge clk);
    res_ready = 1'b0;
    #1 chk("masked_done", 32'(done), 32'd1);
    chk("masked_neg", 32'(neg_flag), 32'd0);
    chk("masked_zero", 32'(zero_flag), 32'd1);
    mn = 1'b0; mz = 1'b1;
    @(negedge clk);

    run_cmd(4, 3'd5, 1'b0, 3, 0, 0);   // three stall cycles before accept
    run_cmd(8, 3'd4, 1'b1, 0, 0, 2);   // preset N=1, Z=0
    run_cmd(0, 3'd6, 1'b1, 0, 0, 1);   // empty command leaves flags alone
    run_cmd(32, 3'd7, 1'b1, 1, 20, 0); // maximum length

    // reset in the middle of a command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_len = LW'(12); cmd_setFlags = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; res_ready = 1'b1; negativeFlags = '0; zeroFlags = '1;
    @(negedge clk);
    res_ready = 1'b0;
    #1 chk("pre_rst_chunk", 32'(chunk_idx), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_chunk_idx", 32'(chunk_idx), 32'd0);
    chk("midrst_neg", 32'(neg_flag), 32'd0);
    chk("midrst_zero", 32'(zero_flag), 32'd0);
    mn = 1'b0; mz = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'd0);
      chk("midrst_idle", 32'(cmd_ready), 32'd1);
    end

`ifdef VECTOR_SEQ_ABORT_EN
    run_cmd(4, 3'd4, 1'b1, 0, 0, 2);   // flags N=1 Z=0 before abort
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_len = LW'(16); cmd_setFlags = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; res_ready = 1'b1; negativeFlags = '0; zeroFlags = '1;
    repeat (2) @(negedge clk);
    #1 chk("abort_chunk", 32'(chunk_idx), 32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; res_ready = 1'b0;
    #1;
    chk("abort_idle", 32'(cmd_ready), 32'd1);
    chk("abort_no_valid", 32'(res_valid), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_neg", 32'(neg_flag), 32'(mn));
    chk("abort_zero", 32'(zero_flag), 32'(mz));
    run_cmd(5, 3'd3, 1'b1, 0, 0, 1);
`endif

    // randomized commands
    for (int k = 0; k < 30; k++) begin
      run_cmd($urandom_range(0, ME), 3'($urandom), 1'($urandom), 0, 30, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
